// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Constants and types shared across the BNN core slice.
//   L1_NEURONS / L2_NEURONS : first- and second-layer neuron counts
//   NUM_NEURONS             : total entries in the weight file
//   NIBBLE_W                : width of the datapath weight-load nibble
//   loader_state_t          : weight loader sequencer states (fixed encoding)
// ---------------------------------------------------------------------------
package bnn_pkg;

  localparam int L1_NEURONS  = 8;
  localparam int L2_NEURONS  = 4;
  localparam int NUM_NEURONS = L1_NEURONS + L2_NEURONS;
  localparam int NIBBLE_W    = 4;

  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_WAIT_BYTE = 3'd1,
    LD_SEND_LO   = 3'd2,
    LD_SEND_HI   = 3'd3,
    LD_FINISH    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/bnn_weight_loader.sv
// ---------------------------------------------------------------------------
// bnn_weight_loader
// Reprograms the BNN weight file from a byte-wide host stream. Each accepted
// byte is replayed to the datapath as two nibbles (low first) on consecutive
// cycles, and the neuron write pointer is mirrored for the host.
//
// Ports:
//   clk, rst_n    clock (rising edge), synchronous active-low reset
//   ena           global enable; low freezes all state
//   start, abort  session open / early close requests (one-cycle)
//   wr_valid, wr_data, wr_ready   host byte handshake
//   load_en, load_nibble          datapath nibble-serial load port
//   busy, done, err, full         session status
//   neuron_idx    next neuron to be written (clears only on reset)
//   checksum      XOR of bytes accepted this session
//                 (only with BNN_LOADER_CHECKSUM_EN defined)
// ---------------------------------------------------------------------------
module bnn_weight_loader #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int IDX_W       = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         wr_valid,
  input  logic [7:0]                   wr_data,
  output logic                         wr_ready,
  output logic                         load_en,
  output logic [bnn_pkg::NIBBLE_W-1:0] load_nibble,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         full,
  output logic [IDX_W-1:0]             neuron_idx
`ifdef BNN_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                   checksum
`endif
);

  import bnn_pkg::*;

  loader_state_t         state;
  logic [NIBBLE_W-1:0]   hi_nib;      // upper half of the accepted byte
  logic                  abort_pend;  // abort seen while a byte is in flight
  logic                  load_en_q;
  logic                  done_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_inc;
  logic                  last_neuron;

  assign idx_inc     = neuron_idx + IDX_W'(1);
  assign last_neuron = (idx_inc == IDX_W'(NUM_NEURONS));

  // Strobes are held in flops while ena is low and masked here, so a paused
  // nibble is re-presented (not lost) once ena returns.
  assign wr_ready = (state == LD_WAIT_BYTE) & ena;
  assign load_en  = load_en_q & ena;
  assign done     = done_q & ena;
  assign err      = err_q & ena;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LD_IDLE;
      hi_nib      <= '0;
      abort_pend  <= 1'b0;
      load_en_q   <= 1'b0;
      load_nibble <= '0;
      busy        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      full        <= 1'b0;
      neuron_idx  <= '0;
`ifdef BNN_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else if (ena) begin
      load_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;

      case (state)
        LD_IDLE: begin
          // A coincident abort is simply ignored here.
          if (start) begin
            if (full) begin
              err_q <= 1'b1;
            end else begin
              state      <= LD_WAIT_BYTE;
              busy       <= 1'b1;
              abort_pend <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
              checksum   <= '0;
`endif
            end
          end
        end

        LD_WAIT_BYTE: begin
          if (wr_valid) begin
            // The host already sees this byte as taken, so an abort in the
            // same cycle is deferred until the byte has been sent.
            state       <= LD_SEND_LO;
            hi_nib      <= wr_data[7:4];
            load_en_q   <= 1'b1;
            load_nibble <= wr_data[3:0];
            abort_pend  <= abort;
`ifdef BNN_LOADER_CHECKSUM_EN
            checksum    <= checksum ^ wr_data;
`endif
          end else if (abort) begin
            state  <= LD_FINISH;
            busy   <= 1'b0;
            done_q <= 1'b1;
          end
        end

        LD_SEND_LO: begin
          state       <= LD_SEND_HI;
          load_en_q   <= 1'b1;
          load_nibble <= hi_nib;
          if (abort) begin
            abort_pend <= 1'b1;
          end
        end

        LD_SEND_HI: begin
          neuron_idx <= idx_inc;
          full       <= last_neuron;
          if (last_neuron || abort_pend || abort) begin
            state  <= LD_FINISH;
            busy   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= LD_WAIT_BYTE;
          end
        end

        LD_FINISH: begin
          state <= LD_IDLE;
        end

        default: begin
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_bnn_weight_loader
// Directed stimulus against bnn_weight_loader. A timing model keyed on the
// count of enabled clock edges predicts every output each cycle; literal
// expectations pin the main scenarios.
// ---------------------------------------------------------------------------
module tb_bnn_weight_loader;

  localparam int NN = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       load_en;
  logic [3:0] load_nibble;
  logic       busy;
  logic       done;
  logic       err;
  logic       full;
  logic [4:0] neuron_idx;
`ifdef BNN_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  bnn_weight_loader #(
    .NUM_NEURONS(NN),
    .IDX_W      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .abort      (abort),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .load_en    (load_en),
    .load_nibble(load_nibble),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .full       (full),
    .neuron_idx (neuron_idx)
`ifdef BNN_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // -------------------------------------------------------------------------
  // Model: k counts enabled edges since reset. Window k is the interval after
  // the k-th enabled edge. Events are stamped with the window they appear in.
  // -------------------------------------------------------------------------
  bit         m_on = 1'b0;
  int         k = 0;
  bit         m_busy = 1'b0;
  int         m_idx = 0;
  int         m_ready_k = 0;
  int         m_idle_k = 0;
  int         m_byte_k = -100;
  logic [7:0] m_byte = 8'h00;
  bit         m_abort_seen = 1'b0;
  int         m_done_k = -100;
  int         m_err_k = -100;
  logic [7:0] m_csum = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b1;
      k = 0;
      m_busy = 1'b0;
      m_idx = 0;
      m_idle_k = 0;
      m_byte_k = -100;
      m_done_k = -100;
      m_err_k = -100;
      m_csum = 8'h00;
    end else if (ena && m_on) begin
      if (m_busy && (k == m_byte_k + 1 || k == m_byte_k + 2)) begin
        // byte in flight: nibbles are going out, aborts are only remembered
        if (abort) m_abort_seen = 1'b1;
        if (k == m_byte_k + 2) begin
          m_idx = m_idx + 1;
          if (m_idx == NN || m_abort_seen) begin
            m_busy   = 1'b0;
            m_done_k = k + 1;
            m_idle_k = k + 2;
          end
        end
      end else if (m_busy && k >= m_ready_k) begin
        if (wr_valid) begin
          m_byte_k     = k;
          m_byte       = wr_data;
          m_ready_k    = k + 3;
          m_abort_seen = abort;
          m_csum       = m_csum ^ wr_data;
        end else if (abort) begin
          m_busy   = 1'b0;
          m_done_k = k + 1;
          m_idle_k = k + 2;
        end
      end else if (!m_busy && k >= m_idle_k && start) begin
        if (m_idx == NN) begin
          m_err_k = k + 1;
        end else begin
          m_busy    = 1'b1;
          m_ready_k = k + 1;
          m_byte_k  = -100;
          m_csum    = 8'h00;
        end
      end
      k = k + 1;
    end
  end

  // observation log used by the literal checks
  logic [3:0] obs_nib[$];
  int         obs_done = 0;
  int         obs_err = 0;

  always @(negedge clk) begin
    bit         e_wr;
    bit         e_le;
    bit         e_dn;
    bit         e_er;
    logic [3:0] e_nib;
    if (m_on) begin
      e_wr  = ena && m_busy && (k >= m_ready_k);
      e_le  = ena && (k == m_byte_k + 1 || k == m_byte_k + 2);
      e_nib = (k == m_byte_k + 1) ? m_byte[3:0] : m_byte[7:4];
      e_dn  = ena && (k == m_done_k);
      e_er  = ena && (k == m_err_k);
      check("wr_ready", int'(wr_ready), int'(e_wr));
      check("load_en", int'(load_en), int'(e_le));
      if (e_le) check("load_nibble", int'(load_nibble), int'(e_nib));
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(e_dn));
      check("err", int'(err), int'(e_er));
      check("full", int'(full), int'(m_idx == NN));
      check("neuron_idx", int'(neuron_idx), m_idx);
`ifdef BNN_LOADER_CHECKSUM_EN
      check("checksum", int'(checksum), int'(m_csum));
`endif
      if (load_en) obs_nib.push_back(load_nibble);
      if (done) obs_done++;
      if (err) obs_err++;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  logic [3:0] exp_nib[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_nib.delete();
    exp_nib.delete();
    obs_done = 0;
    obs_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    wr_valid = 1'b1;
    wr_data  = b;
    for (int i = 0; i < 20 && !got; i++) begin
      got = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    check("byte_accepted", int'(got), 1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_reached", int'(wr_ready), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("session_ended", int'(busy), 0);
    tick();
  endtask

  task automatic check_nibs(input string name);
    check({name, "_count"}, obs_nib.size(), exp_nib.size());
    for (int i = 0; i < exp_nib.size() && i < obs_nib.size(); i++)
      check(name, int'(obs_nib[i]), int'(exp_nib[i]));
  endtask

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    ena = 1'b1;
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(neuron_idx), 0);
    check("rst_full", int'(full), 0);
    check("rst_load_en", int'(load_en), 0);
    check("rst_wr_ready", int'(wr_ready), 0);

    // Full 12-neuron session, bytes 0x00..0x0B back-to-back
    clear_obs();
    pulse_start();
    check("start_busy", int'(busy), 1);
    check("start_wr_ready", int'(wr_ready), 1);
    for (int i = 0; i < NN; i++) send_byte(8'(i));
    wait_idle();
    for (int i = 0; i < NN; i++) begin
      exp_nib.push_back(4'(i));
      exp_nib.push_back(4'h0);
    end
    check_nibs("full_nibs");
    check("full_idx", int'(neuron_idx), 12);
    check("full_flag", int'(full), 1);
    check("full_done_count", obs_done, 1);
`ifdef BNN_LOADER_CHECKSUM_EN
    check("full_checksum", int'(checksum), 8'h00);
`endif

    // Session A: three bytes then abort while waiting
    do_reset();
    clear_obs();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hFF);
    wait_ready();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    exp_nib = '{4'h5, 4'hA, 4'hC, 4'h3, 4'hF, 4'hF};
    check_nibs("sessA_nibs");
    check("sessA_idx", int'(neuron_idx), 3);
    check("sessA_done_count", obs_done, 1);
`ifdef BNN_LOADER_CHECKSUM_EN
    check("sessA_checksum", int'(checksum), 8'h66);
`endif

    // Session B: nine bytes continue from neuron 3 and fill the file
    clear_obs();
    pulse_start();
    for (int i = 1; i <= 9; i++) send_byte(8'(i * 8'h11));
    wait_idle();
    for (int i = 1; i <= 9; i++) begin
      exp_nib.push_back(4'(i));
      exp_nib.push_back(4'(i));
    end
    check_nibs("sessB_nibs");
    check("sessB_idx", int'(neuron_idx), 12);
    check("sessB_full", int'(full), 1);
    check("sessB_done_count", obs_done, 1);

    // start while full is rejected
    clear_obs();
    pulse_start();
    tick();
    check("reject_err_count", obs_err, 1);
    check("reject_busy", int'(busy), 0);
    check("reject_idx", int'(neuron_idx), 12);

    // abort during the low-nibble cycle of byte 0x96
    do_reset();
    clear_obs();
    pulse_start();
    send_byte(8'h96);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abortlo_done_early", int'(done), 0);
    tick();
    check("abortlo_done", int'(done), 1);
    tick();
    exp_nib = '{4'h6, 4'h9};
    check_nibs("abortlo_nibs");
    check("abortlo_idx", int'(neuron_idx), 1);
    check("abortlo_done_count", obs_done, 1);

    // ena held low for 5 cycles between the two nibbles of 0x5A
    clear_obs();
    pulse_start();
    send_byte(8'h5A);
    tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    tick();
    wait_ready();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    exp_nib = '{4'hA, 4'h5};
    check_nibs("ena_gap_nibs");
    check("ena_gap_idx", int'(neuron_idx), 2);

    // reset asserted while the high nibble is going out
    pulse_start();
    send_byte(8'h33);
    tick();
    check("midrst_pre_load_en", int'(load_en), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_load_en", int'(load_en), 0);
    check("midrst_nibble", int'(load_nibble), 0);
    check("midrst_wr_ready", int'(wr_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_full", int'(full), 0);
    check("midrst_idx", int'(neuron_idx), 0);
`ifdef BNN_LOADER_CHECKSUM_EN
    check("midrst_checksum", int'(checksum), 0);
`endif
    rst_n = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
